// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and helpers for the MEM pipeline stage:
//   mem_size_e   - RISC-V funct3 load/store size encoding
//   mem_state_t  - request FSM states (IDLE, WAIT)
//   norm_funct3  - maps illegal size codes for the current XLEN onto W
//   size_mask    - byte-lane mask for an access size, before lane shifting
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'd0,
        F3_H  = 3'd1,
        F3_W  = 3'd2,
        F3_D  = 3'd3,
        F3_BU = 3'd4,
        F3_HU = 3'd5,
        F3_WU = 3'd6
    } mem_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // After normalisation funct3[1:0] is log2(bytes) and funct3[2] means
    // zero-extend; code 7 and the 64-bit-only codes on rv32 become W.
    function automatic logic [2:0] norm_funct3(input logic [2:0] f3, input logic rv64);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: norm_funct3 = f3;
            F3_D, F3_WU:                    norm_funct3 = rv64 ? f3 : 3'(F3_W);
            default:                        norm_funct3 = 3'(F3_W);
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering for the MEM stage.
//   i_funct3     - normalised size/sign code (see mem_stage_pkg::norm_funct3)
//   i_offset     - byte offset inside the XLEN word, already size-aligned
//   i_store_data - store source data (right-justified)
//   i_load_data  - raw memory read word
//   o_be         - byte enables for the store/load lanes
//   o_wdata      - store data replicated across every lane of its size
//   o_load_ext   - selected load lane, sign- or zero-extended to XLEN
// -----------------------------------------------------------------------------
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                  i_funct3,
    input  logic [$clog2(XLEN/8)-1:0]   i_offset,
    input  logic [XLEN-1:0]             i_store_data,
    input  logic [XLEN-1:0]             i_load_data,
    output logic [XLEN/8-1:0]           o_be,
    output logic [XLEN-1:0]             o_wdata,
    output logic [XLEN-1:0]             o_load_ext
);

    localparam int BE_W = XLEN / 8;

    logic [1:0]      w_size;
    logic            w_unsigned;
    logic [7:0]      w_mask8;
    logic [XLEN-1:0] w_shifted;
    logic            w_msb;
    logic            w_fill;

    assign w_size     = i_funct3[1:0];
    assign w_unsigned = i_funct3[2];
    assign w_mask8    = size_mask(i_funct3);
    assign o_be       = w_mask8[BE_W-1:0] << i_offset;

    // Replicating the source across all lanes puts it in the addressed lane
    // without a separate shifter; the byte enables pick the live bytes.
    always_comb begin
        o_wdata = '0;
        for (int i = 0; i < BE_W; i++) begin
            o_wdata[8*i +: 8] = i_store_data[8*(i & ((1 << w_size) - 1)) +: 8];
        end
    end

    assign w_shifted = i_load_data >> {i_offset, 3'b000};

    always_comb begin
        case (w_size)
            2'd0:    w_msb = w_shifted[7];
            2'd1:    w_msb = w_shifted[15];
            2'd2:    w_msb = w_shifted[31];
            default: w_msb = w_shifted[XLEN-1];
        endcase
    end

    assign w_fill = w_msb & ~w_unsigned;

    always_comb begin
        o_load_ext = '0;
        for (int b = 0; b < XLEN; b++) begin
            o_load_ext[b] = (b < (8 << w_size)) ? w_shifted[b] : w_fill;
        end
    end

endmodule

// File: rtl/mem_access_stage_p.sv
// -----------------------------------------------------------------------------
// mem_access_stage_p
// MEM pipeline stage (rv32i/rv64i) between EX/MEM and MEM/WB.
//   Upstream:   in_valid/in_ready, flush, pc_in, alu_in, rs2_data_in,
//               rs2_idx_in, rd_in, regwrite_in, is_load_in, is_store_in,
//               funct3_in
//   Memory:     dmem_addr/wdata/be/read/write out, dmem_resp/rdata in;
//               a request is held stable until dmem_resp
//   Downstream: out_valid, out_pc, out_rd, out_regwrite, out_result, out_exc
//   rst is asynchronous and active-low.
// Build option MEM_MISALIGN_TRAP_EN: misaligned accesses are not issued and
// complete with out_exc=1 and the faulting address as result. Without it,
// the address is aligned down to the access size and out_exc stays 0.
// -----------------------------------------------------------------------------
module mem_access_stage_p
    import mem_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   pc_in,
    input  logic [XLEN-1:0]     alu_in,
    input  logic [XLEN-1:0]     rs2_data_in,
    input  logic [4:0]          rs2_idx_in,
    input  logic [4:0]          rd_in,
    input  logic                regwrite_in,
    input  logic                is_load_in,
    input  logic                is_store_in,
    input  logic [2:0]          funct3_in,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    output logic [XLEN/8-1:0]   dmem_be,
    output logic                dmem_read,
    output logic                dmem_write,
    input  logic                dmem_resp,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                out_valid,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [4:0]          out_rd,
    output logic                out_regwrite,
    output logic [XLEN-1:0]     out_result,
    output logic                out_exc
);

    localparam int   BE_W  = XLEN / 8;
    localparam int   OFF_W = $clog2(BE_W);
    localparam logic RV64  = (XLEN == 64);
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

    mem_state_t         r_state;
    mem_state_t         w_state_nxt;

    // Request captured when the stage enters WAIT
    logic [ADDR_W-1:0]  r_addr;
    logic [XLEN-1:0]    r_wdata;
    logic [BE_W-1:0]    r_be;
    logic               r_read;
    logic               r_write;
    logic               r_flushed;
    logic [ADDR_W-1:0]  r_pc;
    logic [4:0]         r_rd;
    logic               r_regwrite;
    logic [2:0]         r_funct3;
    logic [OFF_W-1:0]   r_offset;
    logic [XLEN-1:0]    r_alu;

    // Last completed load, for store-data forwarding
    logic               r_fwd_vld;
    logic [4:0]         r_fwd_rd;
    logic [XLEN-1:0]    r_fwd_data;

    logic [2:0]         w_funct3;
    logic [OFF_W-1:0]   w_lowmask;
    logic [ADDR_W-1:0]  w_addr_raw;
    logic [ADDR_W-1:0]  w_addr_al;
    logic [OFF_W-1:0]   w_off_raw;
    logic [OFF_W-1:0]   w_off_al;
    logic               w_mem_op;
    logic               w_trap;
    logic               w_issue;
    logic               w_fwd_hit;
    logic [XLEN-1:0]    w_store_src;
    logic [2:0]         w_lane_f3;
    logic [OFF_W-1:0]   w_lane_off;
    logic [BE_W-1:0]    w_be;
    logic [XLEN-1:0]    w_wdata;
    logic [XLEN-1:0]    w_load_ext;
    logic               w_req_read;
    logic               w_req_write;
    logic               w_in_ready;
    logic               w_done;
    logic [ADDR_W-1:0]  w_c_pc;
    logic [4:0]         w_c_rd;
    logic               w_c_regwrite;
    logic               w_c_load;
    logic [XLEN-1:0]    w_c_result;
    logic               w_c_exc;

    assign w_funct3   = norm_funct3(funct3_in, RV64);
    assign w_lowmask  = OFF_W'((8'd1 << w_funct3[1:0]) - 8'd1);
    assign w_addr_raw = ADDR_W'(alu_in);
    assign w_addr_al  = w_addr_raw & WORD_MASK;
    assign w_off_raw  = alu_in[OFF_W-1:0];
    assign w_off_al   = w_off_raw & ~w_lowmask;
    assign w_mem_op   = in_valid & (is_load_in | is_store_in) & ~flush;

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = |(w_off_raw & w_lowmask);
    assign w_trap     = w_mem_op & w_misalign;
`else
    assign w_trap     = 1'b0;
`endif

    assign w_issue     = w_mem_op & ~w_trap;
    assign w_fwd_hit   = r_fwd_vld & (r_fwd_rd != 5'd0) & (rs2_idx_in == r_fwd_rd);
    assign w_store_src = w_fwd_hit ? r_fwd_data : rs2_data_in;

    // In WAIT the lane steering must use the captured size/offset, since the
    // load data arrives while upstream inputs are no longer trusted.
    assign w_lane_f3  = (r_state == WAIT) ? r_funct3 : w_funct3;
    assign w_lane_off = (r_state == WAIT) ? r_offset : w_off_al;

    mem_lane_align #(
        .XLEN (XLEN)
    ) u_lane (
        .i_funct3     (w_lane_f3),
        .i_offset     (w_lane_off),
        .i_store_data (w_store_src),
        .i_load_data  (dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_ext   (w_load_ext)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_req_read  = 1'b0;
        w_req_write = 1'b0;
        w_in_ready  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_read  = w_issue & is_load_in;
                w_req_write = w_issue & is_store_in & ~is_load_in;
                w_in_ready  = ~(w_issue & ~dmem_resp);
                if (in_valid & ~flush) begin
                    if (w_issue & ~dmem_resp) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            WAIT: begin
                // A flushed request stays on the bus until memory answers.
                w_req_read  = r_read;
                w_req_write = r_write;
                if (dmem_resp) begin
                    w_state_nxt = IDLE;
                    w_done      = ~(flush | r_flushed);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if (r_state == WAIT) begin
            w_c_pc       = r_pc;
            w_c_rd       = r_rd;
            w_c_regwrite = r_regwrite;
            w_c_load     = r_read;
            w_c_result   = r_read ? w_load_ext : r_alu;
            w_c_exc      = 1'b0;
        end else begin
            w_c_pc       = pc_in;
            w_c_rd       = rd_in;
            w_c_regwrite = regwrite_in & ~w_trap;
            w_c_load     = is_load_in;
            w_c_result   = w_trap ? XLEN'(w_addr_raw) : (is_load_in ? w_load_ext : alu_in);
            w_c_exc      = w_trap;
        end
    end

    // Gated with rst so the bus drops the moment reset asserts.
    assign dmem_read  = rst & w_req_read;
    assign dmem_write = rst & w_req_write;
    assign dmem_addr  = (r_state == WAIT) ? r_addr  : w_addr_al;
    assign dmem_wdata = (r_state == WAIT) ? r_wdata : w_wdata;
    assign dmem_be    = (r_state == WAIT) ? r_be    : w_be;
    assign in_ready   = w_in_ready;

    // MEM -> MEM/WB boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_flushed    <= 1'b0;
            r_fwd_vld    <= 1'b0;
            r_fwd_rd     <= 5'd0;
            r_fwd_data   <= '0;
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rd       <= 5'd0;
            out_regwrite <= 1'b0;
            out_result   <= '0;
            out_exc      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE) begin
                r_read    <= w_req_read;
                r_write   <= w_req_write;
                r_flushed <= 1'b0;
            end else if (flush) begin
                r_flushed <= 1'b1;
            end
            out_valid <= w_done;
            if (w_done) begin
                out_pc       <= w_c_pc;
                out_rd       <= w_c_rd;
                out_regwrite <= w_c_regwrite;
                out_result   <= w_c_result;
                out_exc      <= w_c_exc;
                // Any completion replaces the record; only a good load keeps it valid.
                r_fwd_vld    <= w_c_load & ~w_c_exc;
                r_fwd_rd     <= w_c_rd;
                r_fwd_data   <= w_load_ext;
            end
        end
    end

    // Request capture boundary (data only, qualified by r_state)
    always_ff @(posedge clk) begin
        if (r_state == IDLE) begin
            r_addr     <= w_addr_al;
            r_wdata    <= w_wdata;
            r_be       <= w_be;
            r_pc       <= pc_in;
            r_rd       <= rd_in;
            r_regwrite <= regwrite_in;
            r_funct3   <= w_funct3;
            r_offset   <= w_off_al;
            r_alu      <= alu_in;
        end
    end

endmodule

// File: tb/tb_mem_access_stage_p.sv
module tb_mem_access_stage_p;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] pc_in;
    logic [31:0] alu_in;
    logic [31:0] rs2_data_in;
    logic [4:0]  rs2_idx_in;
    logic [4:0]  rd_in;
    logic        regwrite_in;
    logic        is_load_in;
    logic        is_store_in;
    logic [2:0]  funct3_in;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_read;
    logic        dmem_write;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic        out_regwrite;
    logic [31:0] out_result;
    logic        out_exc;

    mem_access_stage_p #(.XLEN(32), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .flush        (flush),
        .pc_in        (pc_in),
        .alu_in       (alu_in),
        .rs2_data_in  (rs2_data_in),
        .rs2_idx_in   (rs2_idx_in),
        .rd_in        (rd_in),
        .regwrite_in  (regwrite_in),
        .is_load_in   (is_load_in),
        .is_store_in  (is_store_in),
        .funct3_in    (funct3_in),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_resp    (dmem_resp),
        .dmem_rdata   (dmem_rdata),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_rd       (out_rd),
        .out_regwrite (out_regwrite),
        .out_result   (out_result),
        .out_exc      (out_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                        input logic [31:0] res, input logic exc);
        exp_t e;
        e.pc = pc; e.rd = rd; e.rw = rw; e.res = res; e.exc = exc;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every MEM/WB output beat must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got out_valid=1 pc=0x%0h, expected no completion (t=%0t)", out_pc, $time);
            end else begin
                e = exp_q.pop_front();
                chk("out_pc",       out_pc,       e.pc);
                chk("out_rd",       out_rd,       e.rd);
                chk("out_regwrite", out_regwrite, e.rw);
                chk("out_result",   out_result,   e.res);
                chk("out_exc",      out_exc,      e.exc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; is_load_in = 0; is_store_in = 0; flush = 0; dmem_resp = 0;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] d, input logic [4:0] ri,
                         input logic [4:0] rd, input logic rw, input logic [31:0] pc);
        in_valid = 1; is_load_in = ld; is_store_in = st; funct3_in = f3; alu_in = addr;
        rs2_data_in = d; rs2_idx_in = ri; rd_in = rd; regwrite_in = rw; pc_in = pc; flush = 0;
    endtask

    initial begin
        rst = 0; idle();
        pc_in = 0; alu_in = 0; rs2_data_in = 0; rs2_idx_in = 0; rd_in = 0;
        regwrite_in = 0; funct3_in = 0; dmem_rdata = 0;
        #2;
        chk("rst_dmem_read",  dmem_read,  0);
        chk("rst_dmem_write", dmem_write, 0);
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_exc",    out_exc,    0);
        chk("rst_in_ready",   in_ready,   1);
        repeat (2) @(posedge clk);
        #1 rst = 1;

        // SB 0x103, zero wait states
        step(); drive(0, 1, 3'd0, 32'h103, 32'hAB, 5'd3, 5'd0, 0, 32'h1000); dmem_resp = 1;
        #1;
        chk("sb_write", dmem_write, 1);
        chk("sb_read",  dmem_read,  0);
        chk("sb_be",    dmem_be,    4'b1000);
        chk("sb_wdata", dmem_wdata, 32'hABABABAB);
        chk("sb_addr",  dmem_addr,  32'h100);
        chk("sb_ready", in_ready,   1);
        push(32'h1000, 5'd0, 0, 32'h103, 0);

        // SH 0x206
        step(); drive(0, 1, 3'd1, 32'h206, 32'h1234BEEF, 5'd4, 5'd0, 0, 32'h1004); dmem_resp = 1;
        #1;
        chk("sh_be",    dmem_be,    4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
        chk("sh_addr",  dmem_addr,  32'h204);
        push(32'h1004, 5'd0, 0, 32'h206, 0);

        // LH 0x202, three wait cycles, upstream inputs scrambled while waiting
        step(); drive(1, 0, 3'd1, 32'h202, 32'h0, 5'd0, 5'd6, 1, 32'h1008); dmem_resp = 0;
        dmem_rdata = 32'h8001_1234;
        #1;
        chk("lh_read",  dmem_read,  1);
        chk("lh_write", dmem_write, 0);
        chk("lh_addr",  dmem_addr,  32'h200);
        chk("lh_ready", in_ready,   0);
        push(32'h1008, 5'd6, 1, 32'hFFFF8001, 0);
        for (int i = 0; i < 2; i++) begin
            step(); alu_in = 32'hFFFF_FFF0 + i; funct3_in = 3'd0;
            #1;
            chk("lh_wait_addr",  dmem_addr, 32'h200);
            chk("lh_wait_read",  dmem_read, 1);
            chk("lh_wait_ready", in_ready,  0);
        end
        step(); dmem_resp = 1;
        #1;
        chk("lh_resp_read", dmem_read, 1);
        chk("lh_resp_addr", dmem_addr, 32'h200);

        // LHU 0x202, one wait cycle
        step(); drive(1, 0, 3'd5, 32'h202, 32'h0, 5'd0, 5'd7, 1, 32'h100C); dmem_resp = 0;
        #1;
        chk("lhu_read", dmem_read, 1);
        push(32'h100C, 5'd7, 1, 32'h00008001, 0);
        step(); dmem_resp = 1;

        // LBU / LB 0x209
        step(); drive(1, 0, 3'd4, 32'h209, 32'h0, 5'd0, 5'd10, 1, 32'h1010); dmem_resp = 1;
        dmem_rdata = 32'h0000_9A00;
        #1;
        chk("lbu_addr", dmem_addr, 32'h208);
        push(32'h1010, 5'd10, 1, 32'h0000009A, 0);
        step(); drive(1, 0, 3'd0, 32'h209, 32'h0, 5'd0, 5'd11, 1, 32'h1014); dmem_resp = 1;
        push(32'h1014, 5'd11, 1, 32'hFFFFFF9A, 0);

        // LW x5 then SW rs2=x5 with stale data: forwarded
        step(); drive(1, 0, 3'd2, 32'h300, 32'h0, 5'd0, 5'd5, 1, 32'h1018); dmem_resp = 1;
        dmem_rdata = 32'hDEADBEEF;
        push(32'h1018, 5'd5, 1, 32'hDEADBEEF, 0);
        step(); drive(0, 1, 3'd2, 32'h304, 32'h0, 5'd5, 5'd0, 0, 32'h101C); dmem_resp = 1;
        #1;
        chk("fwd_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("fwd_be",    dmem_be,    4'b1111);
        chk("fwd_addr",  dmem_addr,  32'h304);
        push(32'h101C, 5'd0, 0, 32'h304, 0);

        // LW x0 then SW rs2=x0: no forwarding
        step(); drive(1, 0, 3'd2, 32'h308, 32'h0, 5'd0, 5'd0, 1, 32'h1020); dmem_resp = 1;
        dmem_rdata = 32'h12345678;
        push(32'h1020, 5'd0, 1, 32'h12345678, 0);
        step(); drive(0, 1, 3'd2, 32'h30C, 32'h55AA55AA, 5'd0, 5'd0, 0, 32'h1024); dmem_resp = 1;
        #1;
        chk("x0_nofwd_wdata", dmem_wdata, 32'h55AA55AA);
        push(32'h1024, 5'd0, 0, 32'h30C, 0);

        // LW x5, ALU op in between, SW rs2=x5: record cleared
        step(); drive(1, 0, 3'd2, 32'h310, 32'h0, 5'd0, 5'd5, 1, 32'h1028); dmem_resp = 1;
        dmem_rdata = 32'hCAFEF00D;
        push(32'h1028, 5'd5, 1, 32'hCAFEF00D, 0);
        step(); drive(0, 0, 3'd0, 32'h77, 32'h0, 5'd0, 5'd9, 1, 32'h102C); dmem_resp = 0;
        #1;
        chk("alu_ready", in_ready,   1);
        chk("alu_read",  dmem_read,  0);
        chk("alu_write", dmem_write, 0);
        push(32'h102C, 5'd9, 1, 32'h77, 0);
        step(); drive(0, 1, 3'd2, 32'h314, 32'h11111111, 5'd5, 5'd0, 0, 32'h1030); dmem_resp = 1;
        #1;
        chk("cleared_fwd_wdata", dmem_wdata, 32'h11111111);
        push(32'h1030, 5'd0, 0, 32'h314, 0);

        // Flush in IDLE: dropped, no request
        step(); drive(1, 0, 3'd2, 32'h600, 32'h0, 5'd0, 5'd14, 1, 32'h1034); flush = 1; dmem_resp = 0;
        #1;
        chk("flush_idle_read",  dmem_read, 0);
        chk("flush_idle_ready", in_ready,  1);

        // Flush in WAIT: request held until resp, result discarded
        step(); drive(1, 0, 3'd0, 32'h401, 32'h0, 5'd0, 5'd8, 1, 32'h1038); dmem_resp = 0;
        #1;
        chk("flw_issue_read", dmem_read, 1);
        step(); flush = 1;
        #1;
        chk("flw_hold_read", dmem_read, 1);
        chk("flw_hold_addr", dmem_addr, 32'h400);
        step(); flush = 0;
        #1;
        chk("flw_hold2_read", dmem_read, 1);
        step(); dmem_resp = 1;
        #1;
        chk("flw_resp_read", dmem_read, 1);
        step(); idle();
        #1;
        chk("flw_idle_ready", in_ready,  1);
        chk("flw_idle_read",  dmem_read, 0);

        // Async reset in the middle of WAIT
        step(); drive(1, 0, 3'd2, 32'h500, 32'h0, 5'd0, 5'd12, 1, 32'h103C); dmem_resp = 0;
        #1;
        chk("rstw_issue_read", dmem_read, 1);
        step();
        #1;
        chk("rstw_wait_read", dmem_read, 1);
        #1 rst = 0;
        #1;
        chk("rstw_read",      dmem_read,    0);
        chk("rstw_write",     dmem_write,   0);
        chk("rstw_out_valid", out_valid,    0);
        chk("rstw_out_pc",    out_pc,       0);
        chk("rstw_out_rd",    out_rd,       0);
        chk("rstw_out_rw",    out_regwrite, 0);
        chk("rstw_out_res",   out_result,   0);
        idle();
        step(); rst = 1;

        // LW 0x102 (misaligned word)
        step(); drive(1, 0, 3'd2, 32'h102, 32'h0, 5'd0, 5'd13, 1, 32'h2000);
`ifdef MEM_MISALIGN_TRAP_EN
        dmem_resp = 0;
        #1;
        chk("mis_trap_read",  dmem_read, 0);
        chk("mis_trap_ready", in_ready,  1);
        push(32'h2000, 5'd13, 0, 32'h102, 1);
`else
        dmem_resp = 1; dmem_rdata = 32'h0BADF00D;
        #1;
        chk("mis_read", dmem_read, 1);
        chk("mis_addr", dmem_addr, 32'h100);
        chk("mis_be",   dmem_be,   4'b1111);
        push(32'h2000, 5'd13, 1, 32'h0BADF00D, 0);
`endif
        step(); idle();
        repeat (3) step();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage_p.md
Name: mem_access_stage_p

Overview:
- Parametrised MEM pipeline stage for the rv32i/rv64i core. Sits between EX/MEM and MEM/WB.
- Issues data-memory requests with a multi-cycle request/response handshake and holds each request stable until the response arrives.
- Aligns store data and byte enables per access size, and sign/zero-extends load data before writeback.
- Forwards the previous load's result into a dependent store's write data, and registers the MEM/WB outputs.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- ADDR_W, 32, data-memory address width.
- BE_W, XLEN/8, byte-enable width; derived, never overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  EX/MEM holds a valid instruction
- in_ready  out  1  stage accepts this cycle; the upstream stall is !in_ready
- flush  in  1  kill the instruction currently in the stage
- pc_in  in  ADDR_W  instruction PC
- alu_in  in  XLEN  ALU result: effective address or writeback value
- rs2_data_in  in  XLEN  store source data
- rs2_idx_in  in  5  store source register index
- rd_in  in  5  destination register index
- regwrite_in  in  1  instruction writes rd
- is_load_in  in  1  load
- is_store_in  in  1  store
- funct3_in  in  3  access size/sign (RISC-V encoding)
- dmem_addr  out  ADDR_W  address, aligned down to XLEN/8 bytes
- dmem_wdata  out  XLEN  lane-shifted store data
- dmem_be  out  BE_W  byte enables
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_resp  in  1  access complete
- dmem_rdata  in  XLEN  read data, valid when dmem_resp=1
- out_valid  out  1  MEM/WB holds a valid instruction
- out_pc  out  ADDR_W  registered PC
- out_rd  out  5  registered rd
- out_regwrite  out  1  registered regwrite (0 if excepted)
- out_result  out  XLEN  extended load data, or alu_in for non-loads
- out_exc  out  1  misaligned-access exception flag

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE. All out_* = 0, dmem_read = dmem_write = 0, forwarding record cleared. A request in flight is abandoned; the memory side is reset with the same signal.
- FSM states: IDLE and WAIT.
  - IDLE with in_valid & (is_load|is_store) & !flush: assert dmem_read/dmem_write combinationally.
    - If dmem_resp=1 in the same cycle: complete with zero wait states and stay in IDLE.
    - Otherwise go to WAIT and latch addr, wdata, be and control.
  - WAIT: dmem_read/dmem_write, dmem_addr, dmem_wdata and dmem_be are driven from the latches and held stable. On dmem_resp=1, complete and go to IDLE.
- in_ready = (state==IDLE) & !(mem op & !dmem_resp), i.e. the stage is not stalling.
- Non-memory instructions complete in IDLE in the cycle they are presented.
- Completion: on the next clk edge, the MEM/WB registers load with out_valid=1. Latency is 1 cycle plus the number of memory wait cycles.
- If no instruction completes in a cycle, out_valid goes to 0 on the next edge; there is no downstream backpressure.
- Flush:
  - In IDLE: the instruction is dropped with no request.
  - In WAIT: the request is still held until dmem_resp, so the bus is never retracted. The result is discarded (out_valid=0) and the FSM returns to IDLE.
- Sizes (funct3):
  - 0 = B, 1 = H, 2 = W, 3 = D (only when XLEN=64).
  - 4 = BU, 5 = HU, 6 = WU (only when XLEN=64).
  - Illegal codes are treated as W.
- Store path: dmem_be = size mask << addr[log2(BE_W)-1:0]; dmem_wdata = data replicated/shifted to that lane.
- Load path: the selected lane is extracted and sign- or zero-extended to XLEN.
- Forwarding: the stage records the last completed load (rd, extended data). If the current store has rs2_idx_in == recorded rd, rd != 0, and the record is valid, the recorded data replaces rs2_data_in. The record is invalidated by any completed instruction writing a different rd… rather, every completion overwrites it: a non-load completion clears it.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined: an access whose address is not naturally aligned for its size is never issued to memory. It completes in IDLE in one cycle with out_exc=1 and out_regwrite=0; out_result = the faulting address, zero-extended.
- Undefined: the address low bits below the access size are cleared (aligned down), the access is issued normally, and out_exc is tied to 0.

Decomposition:
- Package mem_stage_pkg: funct3 size enum, mem_state_t {IDLE, WAIT}, and function size_mask(funct3) returning the lane mask.
- Sub-module mem_lane_align (combinational): store shift/byte-enable generation and load extract/extend. It is instantiated once.

Test Plan:
- XLEN=32, SB addr 0x103, data 0xAB, dmem_resp same cycle -> dmem_be=4'b1000, dmem_wdata=0xABABABAB, in_ready=1, out_valid next cycle.
- LH addr 0x202, dmem_rdata=0x8001_xxxx, resp after 3 wait cycles -> in_ready=0 for 3 cycles with address/controls stable; out_result=0xFFFF8001; LHU gives 0x00008001.
- LW x5 then SW with rs2=x5 (stale rs2_data_in=0) -> store wdata equals the loaded word; repeat with rd=x0 -> no forwarding.
- Flush asserted in WAIT -> dmem_read held until resp, then out_valid=0 and FSM returns to IDLE.
- Async reset pulsed mid-WAIT -> dmem_read drops immediately and all outputs are 0 before the next clk edge.
- LW addr 0x102: with MEM_MISALIGN_TRAP_EN -> no dmem_read, out_exc=1, out_result=0x102; without -> access issued at 0x100.
